led_frame_tx: RTL and testbench

LED_FRAME_TX -- requirements
Module: led_frame_tx

---
 rtl/led_frame_tx.sv | 147 ++++++++++++++
 tb/tb_led_frame_tx.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/led_frame_tx.sv
// led_frame_tx: serial frame transmitter for a six-LED receiver.
// The frame is a start bit (0), six data bits LSB first, an optional even
// parity bit and a stop bit (1). Each bit is held for CLKS_PER_BIT cycles.
// Optional feature macro: LED_FRAME_TX_PARITY_EN. When it is defined, a parity
// bit is sent between the data and stop bits (frame = 9 bit periods).
// When it is undefined, the frame is 8 bit periods.
module led_frame_tx #(
    parameter int CLKS_PER_BIT = 4
) (
    input  logic       clk,
    input  logic       resetn,
    input  logic [5:0] data_in,
    input  logic       send,
    output logic       tx_out,
    output logic       busy,
    output logic       done
);

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        START  = 3'd1,
        DATA   = 3'd2,
        PARITY = 3'd3,
        STOP   = 3'd4
    } state_t;

    localparam logic [7:0] LAST_CNT = 8'(CLKS_PER_BIT - 1);
    localparam logic [2:0] LAST_BIT = 3'd5;

    state_t     state, state_n;
    logic [7:0] bit_cnt, bit_cnt_n;
    logic [2:0] bit_idx, bit_idx_n;
    logic [5:0] shreg, shreg_n;
    logic       tx_n;
    logic       done_n;
    logic       bit_end;
`ifdef LED_FRAME_TX_PARITY_EN
    logic       parity, parity_n;
`endif

    assign bit_end = (bit_cnt == LAST_CNT);
    assign busy    = (state != IDLE);

    // Next-state, counter, shift and line-level decode; tx_n is the value the line takes after the edge
    always_comb begin
        // NOTE: every signal gets a default before the case so no path leaves it unassigned (no latches).
        state_n   = state;
        bit_cnt_n = bit_cnt + 8'd1;
        bit_idx_n = bit_idx;
        shreg_n   = shreg;
        tx_n      = tx_out;
        done_n    = 1'b0;
`ifdef LED_FRAME_TX_PARITY_EN
        parity_n  = parity;
`endif
        case (state)
            IDLE: begin
                bit_cnt_n = 8'd0;
                bit_idx_n = 3'd0;
                tx_n      = 1'b1;
                if (send) begin
                    state_n  = START;
                    shreg_n  = data_in;
                    tx_n     = 1'b0;
`ifdef LED_FRAME_TX_PARITY_EN
                    parity_n = ^data_in;
`endif
                end
            end
            START: begin
                if (bit_end) begin
                    bit_cnt_n = 8'd0;
                    state_n   = DATA;
                    tx_n      = shreg[0];
                end
            end
            DATA: begin
                if (bit_end) begin
                    bit_cnt_n = 8'd0;
                    if (bit_idx == LAST_BIT) begin
`ifdef LED_FRAME_TX_PARITY_EN
                        state_n = PARITY;
                        tx_n    = parity;
`else
                        state_n = STOP;
                        tx_n    = 1'b1;
`endif
                    end else begin
                        bit_idx_n = bit_idx + 3'd1;
                        shreg_n   = {1'b0, shreg[5:1]};
                        tx_n      = shreg[1];
                    end
                end
            end
`ifdef LED_FRAME_TX_PARITY_EN
            PARITY: begin
                if (bit_end) begin
                    bit_cnt_n = 8'd0;
                    state_n   = STOP;
                    tx_n      = 1'b1;
                end
            end
`endif
            STOP: begin
                if (bit_end) begin
                    bit_cnt_n = 8'd0;
                    state_n   = IDLE;
                    tx_n      = 1'b1;
                    done_n    = 1'b1;
                end
            end
            default: begin
                state_n   = IDLE;
                bit_cnt_n = 8'd0;
                tx_n      = 1'b1;
            end
        endcase
    end

    // State, counters, shift register and registered line/done outputs
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            // NOTE: the shift register is cleared on reset too, so no stale pattern survives an aborted frame.
            state   <= IDLE;
            bit_cnt <= 8'd0;
            bit_idx <= 3'd0;
            shreg   <= 6'd0;
            tx_out  <= 1'b1;
            done    <= 1'b0;
`ifdef LED_FRAME_TX_PARITY_EN
            parity  <= 1'b0;
`endif
        end else begin
            // NOTE: non-blocking assignments so every flop samples pre-edge values.
            state   <= state_n;
            bit_cnt <= bit_cnt_n;
            bit_idx <= bit_idx_n;
            shreg   <= shreg_n;
            tx_out  <= tx_n;
            done    <= done_n;
`ifdef LED_FRAME_TX_PARITY_EN
            parity  <= parity_n;
`endif
        end
    end

endmodule

// File: tb/tb_led_frame_tx.sv
// tb_led_frame_tx: self-checking bench for led_frame_tx (CLKS_PER_BIT = 4).
// Expected line levels come from a frame model: the list of bit values
// (start, data LSB first, optional parity, stop), each held CPB cycles.
// Honours LED_FRAME_TX_PARITY_EN the same way as the design.
module tb_led_frame_tx;

    localparam int CPB = 4;
`ifdef LED_FRAME_TX_PARITY_EN
    localparam int NB = 9;
`else
    localparam int NB = 8;
`endif
    localparam int FRAME_LEN = NB * CPB;

    logic       clk;
    logic       resetn;
    logic [5:0] data_in;
    logic       send;
    logic       tx_out;
    logic       busy;
    logic       done;

    int checks = 0;
    int errors = 0;

    led_frame_tx #(.CLKS_PER_BIT(CPB)) dut (
        .clk     (clk),
        .resetn  (resetn),
        .data_in (data_in),
        .send    (send),
        .tx_out  (tx_out),
        .busy    (busy),
        .done    (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Frame bit list, index 0 sent first.
    function automatic logic [8:0] frame_bits(input logic [5:0] d);
        logic [8:0] f;
        f = 9'd0;
        f[0] = 1'b0;
        for (int j = 0; j < 6; j++) f[j + 1] = d[j];
`ifdef LED_FRAME_TX_PARITY_EN
        f[7] = ^d;
        f[8] = 1'b1;
`else
        f[7] = 1'b1;
`endif
        return f;
    endfunction

    // Precondition: at a negedge with data_in=d and send=1 set for the accepting edge.
    // Checks ncyc busy cycles; for a full frame also checks the done cycle, then
    // leaves send/data_in set for chaining (chain=1) or idle (chain=0).
    task automatic run_frame(input logic [5:0] d, input bit chain, input logic [5:0] nd, input int ncyc);
        logic [8:0] f;
        f = frame_bits(d);
        for (int i = 1; i <= ncyc; i++) begin
            @(negedge clk);
            check($sformatf("tx c%0d", i), tx_out, f[(i - 1) / CPB]);
            check($sformatf("busy c%0d", i), busy, 1'b1);
            check($sformatf("done c%0d", i), done, 1'b0);
            data_in = 6'($urandom);
            if (!chain) send = 1'($urandom);
        end
        if (ncyc == FRAME_LEN) begin
            @(negedge clk);
            check("tx done cycle", tx_out, 1'b1);
            check("busy done cycle", busy, 1'b0);
            check("done pulse", done, 1'b1);
            send    = chain;
            data_in = nd;
        end
    endtask

    task automatic idle_cycles(input int n, input string tag);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            check({tag, " tx"}, tx_out, 1'b1);
            check({tag, " busy"}, busy, 1'b0);
            check({tag, " done"}, done, 1'b0);
        end
    endtask

    initial begin
        logic [5:0] d, nd;
        bit         chain;

        // Reset held with send pulsing: line stays idle.
        resetn  = 1'b0;
        send    = 1'b0;
        data_in = 6'h2a;
        for (int i = 0; i < 6; i++) begin
            @(negedge clk);
            send = ~send;
            check("rst tx", tx_out, 1'b1);
            check("rst busy", busy, 1'b0);
            check("rst done", done, 1'b0);
        end
        send   = 1'b0;
        resetn = 1'b1;
        idle_cycles(2, "post-rst");

        // Directed 101101, single-cycle send, with ignored send/data activity while busy.
        data_in = 6'b101101;
        send    = 1'b1;
        run_frame(6'b101101, 1'b0, 6'd0, FRAME_LEN);
        idle_cycles(2, "gap1");

        // Parity patterns (parity 1 and parity 0 when the feature is on).
        data_in = 6'b000111;
        send    = 1'b1;
        run_frame(6'b000111, 1'b0, 6'd0, FRAME_LEN);
        idle_cycles(1, "gap2");
        data_in = 6'b101101;
        send    = 1'b1;
        run_frame(6'b101101, 1'b0, 6'd0, FRAME_LEN);
        idle_cycles(1, "gap3");

        // send held high across two frames; second frame uses the done-cycle data.
        data_in = 6'b110010;
        send    = 1'b1;
        run_frame(6'b110010, 1'b1, 6'b011001, FRAME_LEN);
        run_frame(6'b011001, 1'b0, 6'd0, FRAME_LEN);
        idle_cycles(1, "gap4");

        // Reset during data bit 3: line high at once, no done, clean restart.
        data_in = 6'b010110;
        send    = 1'b1;
        run_frame(6'b010110, 1'b0, 6'd0, 4 * CPB + 2);
        resetn = 1'b0;
        #1;
        check("abort tx", tx_out, 1'b1);
        check("abort busy", busy, 1'b0);
        check("abort done", done, 1'b0);
        send = 1'b1;
        idle_cycles(3, "abort hold");
        send   = 1'b0;
        resetn = 1'b1;
        idle_cycles(3, "abort release");
        data_in = 6'b100111;
        send    = 1'b1;
        run_frame(6'b100111, 1'b0, 6'd0, FRAME_LEN);
        idle_cycles(1, "gap5");

        // Randomized frames, randomly chained back-to-back or separated by idle gaps.
        d       = 6'($urandom);
        data_in = d;
        send    = 1'b1;
        for (int n = 0; n < 8; n++) begin
            chain = (n < 7) && ($urandom_range(0, 1) == 1);
            nd    = 6'($urandom);
            run_frame(d, chain, nd, FRAME_LEN);
            if (!chain && n < 7) begin
                idle_cycles(int'($urandom_range(1, 3)), "rnd gap");
                data_in = nd;
                send    = 1'b1;
            end
            d = nd;
        end
        idle_cycles(2, "final");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
